// File: rtl/perceptron_pkg.sv
// Shared types and sizing helpers for the sequential perceptron neuron.
package perceptron_pkg;

  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_STEP = 2'd2,
    ACT_RSVD = 2'd3
  } act_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Wide enough that n_in full-scale products plus a shifted bias never overflow.
  function automatic int acc_w(input int data_w, input int n_in);
    return 2 * data_w + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/perceptron_act.sv
// Activation unit: rescales the accumulator, applies the selected activation
// and saturates to the output width.
module perceptron_act
  import perceptron_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = acc_w(16, 4)
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  act_e                     i_act,
  output logic signed [DATA_W-1:0] o_data,
  output logic                     o_sat
);

  localparam logic signed [ACC_W-1:0] ZERO     = '0;
  localparam logic signed [ACC_W-1:0] STEP_ONE = {{(ACC_W-1){1'b0}}, 1'b1} << FRAC_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] w_r;
  logic signed [ACC_W-1:0] w_y;

  always_comb begin
    w_r    = i_acc >>> FRAC_W;
    w_y    = w_r;
    o_sat  = 1'b0;
    case (i_act)
      ACT_RELU: w_y = w_r[ACC_W-1] ? ZERO : w_r;
      ACT_STEP: w_y = (i_acc > ZERO) ? STEP_ONE : ZERO;
      default:  w_y = w_r;
    endcase
    o_data = w_y[DATA_W-1:0];
    if (w_y > SAT_MAX) begin
      o_data = SAT_MAX[DATA_W-1:0];
      o_sat  = 1'b1;
    end else if (w_y < SAT_MIN) begin
      o_data = SAT_MIN[DATA_W-1:0];
      o_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/perceptron_seq.sv
// Sequential perceptron neuron: one time-shared signed multiplier accumulates
// N_IN weighted inputs onto a bias, then a selectable activation is applied.
module perceptron_seq
  import perceptron_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*DATA_W-1:0]   in_x,
  input  logic [N_IN*DATA_W-1:0]   in_w,
  input  logic [DATA_W-1:0]        in_bias,
  input  logic [1:0]               in_act,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sat,
  output logic                     busy
);

  localparam int ACC_W = acc_w(DATA_W, N_IN);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_e r_state;
  state_e w_nextState;

  logic signed [DATA_W-1:0]   r_x [N_IN];
  logic signed [DATA_W-1:0]   r_w [N_IN];
  act_e                       r_act;
  logic signed [ACC_W-1:0]    r_acc;
  logic [IDX_W-1:0]           r_idx;
  logic signed [DATA_W-1:0]   r_data;
  logic                       r_sat;

  logic signed [DATA_W-1:0]   w_xSel;
  logic signed [DATA_W-1:0]   w_wSel;
  logic signed [2*DATA_W-1:0] w_xExt;
  logic signed [2*DATA_W-1:0] w_wExt;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prodExt;
  logic signed [ACC_W-1:0]    w_biasExt;
  logic signed [DATA_W-1:0]   w_actData;
  logic                       w_actSat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (in_valid)           w_nextState = S_MAC;
      S_MAC:  if (r_idx == LAST_IDX)  w_nextState = S_ACT;
      S_ACT:                          w_nextState = S_DONE;
      S_DONE: if (out_ready)          w_nextState = S_IDLE;
      default:                        w_nextState = S_IDLE;
    endcase
  end

  // Operands are widened before multiplying so the full product is kept.
  assign w_xSel    = r_x[r_idx];
  assign w_wSel    = r_w[r_idx];
  assign w_xExt    = {{DATA_W{w_xSel[DATA_W-1]}}, w_xSel};
  assign w_wExt    = {{DATA_W{w_wSel[DATA_W-1]}}, w_wSel};
  assign w_prod    = w_xExt * w_wExt;
  assign w_prodExt = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_biasExt = {{(ACC_W-DATA_W){in_bias[DATA_W-1]}}, in_bias};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
      r_act  <= ACT_ID;
      r_acc  <= '0;
      r_idx  <= '0;
      r_data <= '0;
      r_sat  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_IN; i++) begin
              r_x[i] <= in_x[i*DATA_W +: DATA_W];
              r_w[i] <= in_w[i*DATA_W +: DATA_W];
            end
            r_act <= act_e'(in_act);
            r_acc <= w_biasExt <<< FRAC_W;
            r_idx <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prodExt;
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
        S_ACT: begin
          r_data <= w_actData;
          r_sat  <= w_actSat;
        end
        default: ;
      endcase
    end
  end

  perceptron_act #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_act (
    .i_acc  (r_acc),
    .i_act  (r_act),
    .o_data (w_actData),
    .o_sat  (w_actSat)
  );

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_data;
  assign out_sat   = r_sat;

endmodule

// File: tb/tb_perceptron_seq.sv
// Bench for perceptron_seq: directed cases on an N_IN=4 build, then random
// regression of N_IN=4, 1 and 7 builds against an arithmetic reference model.
module tb_perceptron_seq;

  localparam int NMAX = 7;
  localparam int DW   = 16;

  int nOf [3] = '{4, 1, 7};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic               inValid  [3];
  logic               outReady [3];
  logic               inReady  [3];
  logic               outValid [3];
  logic               outSat   [3];
  logic               busyS    [3];
  logic signed [DW-1:0] outData [3];

  logic signed [DW-1:0] tx [NMAX];
  logic signed [DW-1:0] tw [NMAX];
  logic signed [DW-1:0] inBias;
  logic [1:0]           inAct;

  logic [4*DW-1:0] x4, w4;
  logic [DW-1:0]   x1, w1;
  logic [7*DW-1:0] x7, w7;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x4[i*DW +: DW] = tx[i];
      w4[i*DW +: DW] = tw[i];
    end
    x1 = tx[0];
    w1 = tw[0];
    for (int i = 0; i < 7; i++) begin
      x7[i*DW +: DW] = tx[i];
      w7[i*DW +: DW] = tw[i];
    end
  end

  perceptron_seq #(.N_IN(4), .DATA_W(DW), .FRAC_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_x(x4), .in_w(w4), .in_bias(inBias), .in_act(inAct),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(outData[0]), .out_sat(outSat[0]), .busy(busyS[0])
  );

  perceptron_seq #(.N_IN(1), .DATA_W(DW), .FRAC_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_x(x1), .in_w(w1), .in_bias(inBias), .in_act(inAct),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(outData[1]), .out_sat(outSat[1]), .busy(busyS[1])
  );

  perceptron_seq #(.N_IN(7), .DATA_W(DW), .FRAC_W(8)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_x(x7), .in_w(w7), .in_bias(inBias), .in_act(inAct),
    .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_data(outData[2]), .out_sat(outSat[2]), .busy(busyS[2])
  );

  task automatic checkVal(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int d, input longint expD, input bit expS, input string tag);
    checkVal({tag, "_data"}, outData[d], expD);
    checkVal({tag, "_sat"}, outSat[d], expS);
  endtask

  // Reference: exact integer sum, floor division by 2**FRAC_W, clamp.
  function automatic void model(input int n, input logic signed [DW-1:0] bias,
                                input logic [1:0] act, output longint expD, output bit expS);
    longint acc, r, y;
    acc = longint'(bias) * 256;
    for (int i = 0; i < n; i++) acc += longint'(tx[i]) * longint'(tw[i]);
    if (acc >= 0) r = acc / 256;
    else          r = -((-acc + 255) / 256);
    case (act)
      2'd1:    y = (r < 0) ? 0 : r;
      2'd2:    y = (acc > 0) ? 256 : 0;
      default: y = r;
    endcase
    expS = 1'b1;
    if (y > 32767)       expD = 32767;
    else if (y < -32768) expD = -32768;
    else begin
      expD = y;
      expS = 1'b0;
    end
  endfunction

  task automatic clearXW();
    for (int i = 0; i < NMAX; i++) begin
      tx[i] = '0;
      tw[i] = '0;
    end
  endtask

  // Present one operand vector for a single accepting edge, then scramble the
  // inputs so anything not latched at acceptance would corrupt the result.
  task automatic applyStimulus(input int d, input logic signed [DW-1:0] bias, input logic [1:0] act);
    @(negedge clk);
    checkVal("in_ready_idle", inReady[d], 1);
    inBias     = bias;
    inAct      = act;
    inValid[d] = 1'b1;
    @(posedge clk);
    #1;
    inValid[d] = 1'b0;
    inAct      = ~act;
    inBias     = DW'($urandom);
    for (int i = 0; i < NMAX; i++) begin
      tx[i] = DW'($urandom);
      tw[i] = DW'($urandom);
    end
  endtask

  task automatic waitValid(input int d, input int expLat, input string tag);
    int lat = 0;
    while (outValid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkVal({tag, "_latency"}, lat, expLat);
  endtask

  task automatic finishTxn(input int d, input string tag);
    @(negedge clk);
    outReady[d] = 1'b1;
    @(posedge clk);
    #1;
    outReady[d] = 1'b0;
    checkVal({tag, "_valid_drop"}, outValid[d], 0);
    checkVal({tag, "_ready_back"}, inReady[d], 1);
  endtask

  task automatic directedTxn(input logic signed [DW-1:0] bias, input logic [1:0] act,
                             input longint expD, input bit expS, input string tag);
    applyStimulus(0, bias, act);
    waitValid(0, 5, tag);
    checkOutput(0, expD, expS, tag);
    finishTxn(0, tag);
  endtask

  task automatic randomTxn(input int d);
    longint expD;
    bit     expS;
    logic signed [DW-1:0] bias;
    logic [1:0] act;
    bit big;
    big = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < NMAX; i++) begin
      if (big) begin
        tx[i] = DW'($urandom);
        tw[i] = DW'($urandom);
      end else begin
        tx[i] = DW'(int'($urandom_range(0, 2047)) - 1024);
        tw[i] = DW'(int'($urandom_range(0, 2047)) - 1024);
      end
    end
    bias = big ? DW'($urandom) : DW'(int'($urandom_range(0, 4095)) - 2048);
    act  = 2'($urandom_range(0, 3));
    model(nOf[d], bias, act, expD, expS);
    applyStimulus(d, bias, act);
    waitValid(d, nOf[d] + 1, "rand");
    checkOutput(d, expD, expS, "rand");
    finishTxn(d, "rand");
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      inValid[d]  = 1'b0;
      outReady[d] = 1'b0;
    end
    inBias = '0;
    inAct  = '0;
    clearXW();

    #1 rst_n = 1'b0;
    #2;
    checkVal("rst_out_valid", outValid[0], 0);
    checkVal("rst_out_data", outData[0], 0);
    checkVal("rst_out_sat", outSat[0], 0);
    checkVal("rst_busy", busyS[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("rst_in_ready", inReady[0], 1);

    clearXW();
    tx[0] = 2560; tx[1] = 768; tw[0] = 1280; tw[1] = 1280;
    directedTxn(0, 2'd0, 16640, 1'b0, "identity");

    clearXW(); tx[0] = 256; tw[0] = -512;
    directedTxn(-256, 2'd1, 0, 1'b0, "relu_neg");
    clearXW(); tx[0] = 256; tw[0] = -512;
    directedTxn(-256, 2'd0, -768, 1'b0, "ident_neg");
    clearXW(); tx[0] = 256; tw[0] = -512;
    directedTxn(-256, 2'd2, 0, 1'b0, "step_neg");
    clearXW(); tx[0] = 256; tw[0] = -512;
    directedTxn(-256, 2'd3, -768, 1'b0, "rsvd_neg");
    clearXW(); tx[0] = 256; tw[0] = -512;
    directedTxn(768, 2'd2, 256, 1'b0, "step_pos");
    clearXW(); tx[0] = 256; tw[0] = -512;
    directedTxn(512, 2'd2, 0, 1'b0, "step_zero");
    clearXW(); tx[0] = 256; tw[0] = 512;
    directedTxn(-256, 2'd1, 256, 1'b0, "relu_pos");

    for (int i = 0; i < 4; i++) begin tx[i] = 32767; tw[i] = 32767; end
    directedTxn(0, 2'd0, 32767, 1'b1, "sat_pos");
    for (int i = 0; i < 4; i++) begin tx[i] = 32767; tw[i] = -32768; end
    directedTxn(0, 2'd0, -32768, 1'b1, "sat_neg");

    clearXW();
    tx[0] = 2560; tx[1] = 768; tw[0] = 1280; tw[1] = 1280;
    applyStimulus(0, 0, 2'd0);
    waitValid(0, 5, "bp");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      inValid[0] = (k % 2 == 0);
      tx[0] = DW'($urandom);
      @(posedge clk);
      #1;
      checkVal("bp_valid_held", outValid[0], 1);
      checkVal("bp_data_held", outData[0], 16640);
      checkVal("bp_in_ready_low", inReady[0], 0);
    end
    inValid[0] = 1'b0;
    finishTxn(0, "bp");
    checkVal("bp_nothing_accepted", busyS[0], 0);

    clearXW();
    tx[0] = 2560; tx[1] = 768; tw[0] = 1280; tw[1] = 1280;
    applyStimulus(0, 0, 2'd0);
    @(posedge clk);
    #2;
    checkVal("midrst_busy_before", busyS[0], 1);
    rst_n = 1'b0;
    #1;
    checkVal("midrst_out_valid", outValid[0], 0);
    checkVal("midrst_out_data", outData[0], 0);
    checkVal("midrst_out_sat", outSat[0], 0);
    checkVal("midrst_busy", busyS[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("midrst_in_ready", inReady[0], 1);
    clearXW();
    tx[0] = 2560; tx[1] = 768; tw[0] = 1280; tw[1] = 1280;
    directedTxn(0, 2'd0, 16640, 1'b0, "post_rst");

    for (int d = 0; d < 3; d++) begin
      for (int v = 0; v < 350; v++) randomTxn(d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perceptron_seq.md
Name: perceptron_seq

Overview:
Parametrised sequential perceptron neuron. Generalises the two-input, shared-weight combinational perceptron in four ways: N_IN inputs, one weight per input, a bias term, and a selectable activation function. Uses one signed fixed-point multiplier, time-shared over the inputs (serial MAC, one product per cycle). Valid/ready handshakes on both sides allow chaining into layers.

Parameters:
N_IN, 4, number of inputs/weights per neuron (>=1)
DATA_W, 16, width of x, w, bias, output (signed two's complement)
FRAC_W, 8, fractional bits of all fixed-point operands (1.0 = 2**FRAC_W)
ACC_W, 2*DATA_W+$clog2(N_IN)+1, accumulator width (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand vector valid
in_ready  out  1  block can accept operands (high only in IDLE)
in_x  in  N_IN*DATA_W  inputs; element i at [i*DATA_W +: DATA_W]
in_w  in  N_IN*DATA_W  weights; same packing
in_bias  in  DATA_W  bias, same Q format
in_act  in  2  activation: 0 identity, 1 ReLU, 2 step, 3 reserved (= identity)
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accepts result
out_data  out  DATA_W  activated, saturated result
out_sat  out  1  result was clipped by saturation
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state, including mid-MAC): state=IDLE, acc=0, idx=0, out_valid=0, out_data=0, out_sat=0. Operand regs are cleared. On release, in_ready=1.
- FSM: IDLE -> MAC -> ACT -> DONE -> IDLE.
- IDLE: in_ready=1. Edge with in_valid=1 latches in_x, in_w and in_act. It sets acc = sext(in_bias) <<< FRAC_W and idx=0, then goes to MAC.
- MAC: per edge, acc += sext(x[idx]*w[idx]), with the product signed at 2*DATA_W; idx++. After N_IN edges (idx==N_IN-1 on the edge), go to ACT. in_valid is ignored.
- ACT: one edge. Registers out_data/out_sat from the activation unit, sets out_valid=1, goes to DONE.
- DONE: out_valid=1; out_data and out_sat are stable. Edge with out_ready=1: out_valid=0, go to IDLE. in_ready is low in DONE; no overlap with acceptance.
- Latency: out_valid is high after acceptance edge + N_IN+1 edges. Minimum initiation interval is N_IN+3 cycles.
- Arithmetic:
  - r = acc >>> FRAC_W (arithmetic shift, truncation toward -inf).
  - identity: y=r.
  - ReLU: y = r<0 ? 0 : r.
  - step: y = acc>0 ? (1<<<FRAC_W) : 0 (acc==0 gives 0).
  - Saturate y to [-2**(DATA_W-1), 2**(DATA_W-1)-1]. out_sat=1 iff clipping occurred.
- ACC_W guarantees no accumulator overflow for any operands.
- in_act is sampled only at acceptance; later changes have no effect on the transaction in flight.

Decomposition:
- Package perceptron_pkg:
  - act_e enum (ACT_ID, ACT_RELU, ACT_STEP, ACT_RSVD).
  - state_e enum (S_IDLE, S_MAC, S_ACT, S_DONE).
  - Function acc_w(data_w, n_in).
- Sub-module perceptron_act (combinational): acc, act -> data, sat. Performs shift, activation and saturation; unit-testable alone.

Test Plan:
(Common config: DATA_W=16, FRAC_W=8, N_IN=4; 1.0=256.)
1. Identity: x=[2560,768,0,0], w=[1280,1280,0,0], bias=0, act=0 -> out_data=16640 (65.0), out_sat=0. out_valid rises exactly 5 edges after acceptance.
2. ReLU/identity: x=[256,0,0,0], w=[-512,0,0,0], bias=-256 -> act=1 gives 0; act=0 gives -768; act=2 gives 0. Same x,w with bias=+768 and act=2 -> 256. Sum exactly 0 with act=2 -> 0.
3. Saturation: all x=w=32767, act=0 -> out_data=32767, out_sat=1. x=32767, w=-32768 everywhere -> out_data=-32768, out_sat=1.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulse in_valid meanwhile -> out_valid/out_data stable, in_ready=0, nothing accepted. Raise out_ready -> out_valid=0 and in_ready=1 next cycle. Back-to-back transactions give correct results.
5. Reset mid-operation: drop rst_n during the 2nd MAC cycle -> out_valid, out_data, out_sat and busy go 0 without waiting for a clock. After release, in_ready=1 and a fresh test-1 transaction yields 16640.
6. N_IN=1 and N_IN=7 builds (random regression vs. reference model, 1000 vectors, all modes) -> bit-exact match including out_sat; latency = N_IN+1.
